pipe_core_mc: RTL
=================

// Module: pipe_core_mc
// PURPOSE
//  Parametrised successor of the 3-stage integer pipeline: D (decode reg) -> EX -> WB.
//  Instructions arrive over a valid/ready stream; results leave on a write-back port.
//  Adds: RV32I R/I-type + LUI decode, sign-extended immediates, retire counter, and an iterative MUL that stalls the pipe.
//  Sits between the instruction-fetch block and the debug/trace sink.
// PARAMETERS
//  XLEN           32  datapath width; power of two, >=8
//  NUM_REGS       32  architectural registers, x0 hardwired 0; RA_W = $clog2(NUM_REGS)
//  MUL_EN         1   0: MUL decodes as illegal
//  MUL_BITS       4   multiplier bits consumed per cycle; divides XLEN; MUL_LAT = XLEN/MUL_BITS
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-low reset
//  instr_valid  in   1     instr holds a valid instruction
//  instr_ready  out  1     core accepts instr this cycle
//  instr        in   32    RV32 encoding
//  wb_valid     out  1     wb_rd/wb_data hold a retiring result this cycle
//  wb_rd        out  RA_W  destination register
//  wb_data      out  XLEN  result, written to the register file at the end of this cycle
//  illegal      out  1     one-cycle pulse: the EX-slot instruction was undecodable; it retires as NOP
//  retire_cnt   out  32    count of wb_valid cycles; wraps at 2^32
// BEHAVIOUR
//  Reset (rst=0, async): D/W valid=0, mul idle, all regs=0, retire_cnt=0, outputs 0; instr_ready=1 after release.
//  Accept on instr_valid&&instr_ready at edge N -> D valid in cycle N+1 -> result latched to W at edge N+1.
//   wb_valid is high in cycle N+2; regfile written at edge N+2. Single-cycle op latency = 2; throughput = 1/clk.
//  instr_ready = !d_valid || ex_done; ex_done = 1 for non-MUL ops, 1 only in the final MUL cycle.
//  Decode:
//   0110011: ADD, SUB (f7[5]), SLL, SLT, SLTU, XOR, SRL, SRA (f7[5]), OR, AND.
//   f7=0000001 & f3=000: MUL, low XLEN bits of the product.
//   0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; imm = sign-extended instr[31:20].
//   0110111: LUI = {instr[31:12], 12'b0} truncated or sign-extended to XLEN.
//   Anything else, or a wrong f7 -> illegal pulse in the cycle the op occupies EX; wb_valid=0 for that slot.
//   Shift amount = operand[$clog2(XLEN)-1:0].
//   rd==0 results are written nowhere, but still produce wb_valid=1 with wb_rd=0; retire_cnt counts them.
//  Forwarding: if W valid && wb_rd!=0 && wb_rd==rs1/rs2 of D, the operand takes wb_data, not the regfile.
//   No other hazards exist.
//  MUL FSM: IDLE -> BUSY (load operands, after forwarding, at the first EX cycle) -> BUSY for MUL_LAT cycles -> IDLE.
//   While BUSY, D is held, instr_ready=0, and W gets bubbles (wb_valid=0).
//   The product is latched to W in the final cycle; a back-to-back MUL re-enters BUSY with no idle cycle.
//   Operands are captured once, so a W-forward seen at the start is the only bypass used.
//  Reset asserted mid-MUL: the op is discarded, nothing retires.
//  Arithmetic is modulo 2^XLEN. SLT/SLTU return 0/1 zero-extended.
//  Regfile read is async, write sync. x0 always reads 0.
// STRUCTURE
//  pipe_core_pkg: opcode/funct constants, the MUL funct7, alu_op_t enum (ADD..AND, MUL, LUI, NOP),
//   and the decoded-instruction struct (rd, rs1, rs2, imm, alu_op, use_imm, illegal).
//  Sub-module iter_mul #(XLEN, MUL_BITS): start/a/b in, done/product out; shift-add MUL_BITS per cycle.
//  Top module: decode, regfile, forwarding muxes, ALU, and the D/W pipeline registers.
// TESTING
//  1. ADDI x1,x0,5; ADDI x2,x0,-3 back-to-back -> wb (1,5) then (2,0xFFFFFFFD) on consecutive cycles; retire_cnt=2.
//  2. ADDI x1,x0,7; ADD x3,x1,x1 -> forwarding gives wb (3,14); no stall.
//  3. x4=6, x5=-7; MUL x6,x4,x5 with MUL_BITS=4 -> instr_ready low 7 cycles, wb (6,0xFFFFFFD6) 8 cycles after D; MUL x7,x6,x6 next -> 1764.
//  4. Instruction 0xFFFFFFFF -> illegal pulse, wb_valid=0, retire_cnt unchanged; next ADDI retires normally.
//  5. SRAI x8,x9,4 with x9=0x80000000 -> 0xF8000000; LUI x10,0x12345 -> 0x12345000; ADDI x0,x0,9 -> reading x0 gives 0.
//  6. Drive rst low mid-MUL -> outputs 0 immediately, retire_cnt=0; after release instr_ready=1 and all regs read 0.

Source files
------------

// File: rtl/pipe_core_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_core_mc_pkg
//  Purpose  : RV32I opcode/funct constants, ALU operation enum, decoded
//             instruction record and the instruction decode function.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_core_mc_pkg;

  localparam logic [6:0] C_OP_REG  = 7'b0110011;
  localparam logic [6:0] C_OP_IMM  = 7'b0010011;
  localparam logic [6:0] C_OP_LUI  = 7'b0110111;

  localparam logic [6:0] C_F7_BASE = 7'b0000000;
  localparam logic [6:0] C_F7_ALT  = 7'b0100000;
  localparam logic [6:0] C_F7_MUL  = 7'b0000001;

  localparam logic [2:0] C_F3_ADD  = 3'b000;
  localparam logic [2:0] C_F3_SLL  = 3'b001;
  localparam logic [2:0] C_F3_SLT  = 3'b010;
  localparam logic [2:0] C_F3_SLTU = 3'b011;
  localparam logic [2:0] C_F3_XOR  = 3'b100;
  localparam logic [2:0] C_F3_SR   = 3'b101;
  localparam logic [2:0] C_F3_OR   = 3'b110;
  localparam logic [2:0] C_F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_LUI, ALU_NOP
  } alu_op_t;

  // imm is 32 bits, already sign-extended; the core widens/truncates to XLEN
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins, input logic mul_en);
    dec_t       d;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op        = ins[6:0];
    f3        = ins[14:12];
    f7        = ins[31:25];
    d.rd      = ins[11:7];
    d.rs1     = ins[19:15];
    d.rs2     = ins[24:20];
    d.imm     = {{20{ins[31]}}, ins[31:20]};
    d.alu_op  = ALU_NOP;
    d.use_imm = 1'b0;
    d.illegal = 1'b0;
    case (op)
      C_OP_REG: begin
        if (f7 == C_F7_BASE) begin
          case (f3)
            C_F3_ADD:  d.alu_op = ALU_ADD;
            C_F3_SLL:  d.alu_op = ALU_SLL;
            C_F3_SLT:  d.alu_op = ALU_SLT;
            C_F3_SLTU: d.alu_op = ALU_SLTU;
            C_F3_XOR:  d.alu_op = ALU_XOR;
            C_F3_SR:   d.alu_op = ALU_SRL;
            C_F3_OR:   d.alu_op = ALU_OR;
            default:   d.alu_op = ALU_AND;
          endcase
        end else if (f7 == C_F7_ALT && f3 == C_F3_ADD) begin
          d.alu_op = ALU_SUB;
        end else if (f7 == C_F7_ALT && f3 == C_F3_SR) begin
          d.alu_op = ALU_SRA;
        end else if (f7 == C_F7_MUL && f3 == C_F3_ADD && mul_en) begin
          d.alu_op = ALU_MUL;
        end else begin
          d.illegal = 1'b1;
        end
      end
      C_OP_IMM: begin
        d.use_imm = 1'b1;
        case (f3)
          C_F3_ADD:  d.alu_op = ALU_ADD;
          C_F3_SLT:  d.alu_op = ALU_SLT;
          C_F3_SLTU: d.alu_op = ALU_SLTU;
          C_F3_XOR:  d.alu_op = ALU_XOR;
          C_F3_OR:   d.alu_op = ALU_OR;
          C_F3_AND:  d.alu_op = ALU_AND;
          C_F3_SLL: begin
            if (f7 == C_F7_BASE) d.alu_op = ALU_SLL;
            else                 d.illegal = 1'b1;
          end
          default: begin
            if (f7 == C_F7_BASE)     d.alu_op = ALU_SRL;
            else if (f7 == C_F7_ALT) d.alu_op = ALU_SRA;
            else                     d.illegal = 1'b1;
          end
        endcase
      end
      C_OP_LUI: begin
        d.imm     = {ins[31:12], 12'b0};
        d.alu_op  = ALU_LUI;
        d.use_imm = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // an undecodable slot must not reach any functional unit
    if (d.illegal) d.alu_op = ALU_NOP;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_core_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_core_mc_if
//  Purpose  : Instruction stream in, write-back/trace port out.
//             master = fetch/trace side, slave = core side.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_core_mc_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [31:0]     retire_cnt;

  modport master (
    output instr_valid, instr,
    input  instr_ready, wb_valid, wb_rd, wb_data, illegal, retire_cnt
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, wb_valid, wb_rd, wb_data, illegal, retire_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_core_mc_iter_mul.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_core_mc_iter_mul
//  Purpose  : Iterative shift-add multiplier, MUL_BITS multiplier bits per
//             cycle. The first step runs combinationally in the start cycle,
//             so done rises in the (XLEN/MUL_BITS)-th cycle counting that one.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_core_mc_iter_mul #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int C_LAT   = XLEN / MUL_BITS;
  localparam int C_CNT_W = (C_LAT > 1) ? $clog2(C_LAT) : 1;

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]    r_acc;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;

  logic [XLEN-1:0]    w_a_cur;
  logic [MUL_BITS-1:0] w_b_lo;
  logic [XLEN-1:0]    w_sum;
  logic               w_first;
  logic               w_last;

  // one shift-add step: from live operands when idle, from saved state when busy
  always_comb begin
    w_first = (r_state == C_IDLE) && start;
    w_a_cur = (r_state == C_BUSY) ? r_a : a;
    w_b_lo  = (r_state == C_BUSY) ? r_b[MUL_BITS-1:0] : b[MUL_BITS-1:0];
    w_sum   = (r_state == C_BUSY) ? r_acc : '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (w_b_lo[j]) w_sum = w_sum + (w_a_cur << j);
    end
    if (C_LAT == 1) w_last = w_first;
    else            w_last = (r_state == C_BUSY) && (r_cnt == C_CNT_W'(C_LAT - 1));
  end

  assign done    = w_last;
  assign product = w_sum;

  // IDLE captures operands on start; BUSY walks the multiplier until the last chunk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (r_state == C_IDLE) begin
      if (start && (C_LAT > 1)) begin
        r_state <= C_BUSY;
        r_cnt   <= C_CNT_W'(1);
        r_acc   <= w_sum;
        r_a     <= a << MUL_BITS;
        r_b     <= b >> MUL_BITS;
      end
    end else begin
      r_acc <= w_sum;
      r_a   <= r_a << MUL_BITS;
      r_b   <= r_b >> MUL_BITS;
      r_cnt <= r_cnt + C_CNT_W'(1);
      if (w_last) r_state <= C_IDLE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_core_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_core_mc
//  Purpose  : D -> EX -> WB integer pipeline: RV32I R/I-type + LUI, optional
//             iterative MUL that holds D, W->D operand forwarding, retire count.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_core_mc
  import pipe_core_mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int MUL_EN   = 1,
  parameter int MUL_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipe_core_mc_if.slave  bus
);

  localparam int C_RA_W = $clog2(NUM_REGS);
  localparam int C_SH_W = $clog2(XLEN);

  logic              r_d_valid;
  logic [31:0]       r_d_instr;
  logic [XLEN-1:0]   r_regs [NUM_REGS];
  logic              r_w_valid;
  logic [C_RA_W-1:0] r_w_rd;
  logic [XLEN-1:0]   r_w_data;
  logic [31:0]       r_retire_cnt;

  dec_t              w_dec;
  logic [C_RA_W-1:0] w_rs1_idx;
  logic [C_RA_W-1:0] w_rs2_idx;
  logic [C_RA_W-1:0] w_rd_idx;
  logic [XLEN-1:0]   w_rf_a;
  logic [XLEN-1:0]   w_rf_b;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_op_b;
  logic [XLEN-1:0]   w_imm_x;
  logic [C_SH_W-1:0] w_shamt;
  logic [XLEN-1:0]   w_result;
  logic              w_mul_done;
  logic [XLEN-1:0]   w_mul_product;
  logic              w_ex_done;
  logic              w_ready;

  // decode straight out of the D register; EX works on it in the same cycle
  always_comb begin
    w_dec = decode(r_d_instr, (MUL_EN != 0));
  end

  assign w_rs1_idx = w_dec.rs1[C_RA_W-1:0];
  assign w_rs2_idx = w_dec.rs2[C_RA_W-1:0];
  assign w_rd_idx  = w_dec.rd[C_RA_W-1:0];

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_imm_x = {{(XLEN-32){w_dec.imm[31]}}, w_dec.imm};
    end else if (XLEN == 32) begin : g_imm_eq
      assign w_imm_x = w_dec.imm;
    end else begin : g_imm_narrow
      assign w_imm_x = w_dec.imm[XLEN-1:0];
    end
  endgenerate

  // asynchronous register-file read, x0 forced to zero
  assign w_rf_a = (w_rs1_idx == '0) ? '0 : r_regs[w_rs1_idx];
  assign w_rf_b = (w_rs2_idx == '0) ? '0 : r_regs[w_rs2_idx];

  // W holds the only result not yet in the regfile, so it is the only bypass
  assign w_op_a    = (r_w_valid && r_w_rd != '0 && r_w_rd == w_rs1_idx) ? r_w_data : w_rf_a;
  assign w_rs2_val = (r_w_valid && r_w_rd != '0 && r_w_rd == w_rs2_idx) ? r_w_data : w_rf_b;
  assign w_op_b    = w_dec.use_imm ? w_imm_x : w_rs2_val;
  assign w_shamt   = w_op_b[C_SH_W-1:0];

  generate
    if (MUL_EN != 0) begin : g_mul_on
      logic w_mul_start;
      assign w_mul_start = r_d_valid && (w_dec.alu_op == ALU_MUL);
      pipe_core_mc_iter_mul #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_op_a),
        .b       (w_op_b),
        .done    (w_mul_done),
        .product (w_mul_product)
      );
    end else begin : g_mul_off
      assign w_mul_done    = 1'b0;
      assign w_mul_product = '0;
    end
  endgenerate

  // single-cycle ALU; MUL result comes from the iterative unit
  always_comb begin
    w_result = '0;
    case (w_dec.alu_op)
      ALU_ADD:  w_result = w_op_a + w_op_b;
      ALU_SUB:  w_result = w_op_a - w_op_b;
      ALU_SLL:  w_result = w_op_a << w_shamt;
      ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      ALU_XOR:  w_result = w_op_a ^ w_op_b;
      ALU_SRL:  w_result = w_op_a >> w_shamt;
      ALU_SRA:  w_result = $signed(w_op_a) >>> w_shamt;
      ALU_OR:   w_result = w_op_a | w_op_b;
      ALU_AND:  w_result = w_op_a & w_op_b;
      ALU_MUL:  w_result = w_mul_product;
      ALU_LUI:  w_result = w_imm_x;
      default:  w_result = '0;
    endcase
  end

  assign w_ex_done = (w_dec.alu_op != ALU_MUL) || w_mul_done;
  assign w_ready   = !r_d_valid || w_ex_done;

  // D register: refills whenever EX finishes with its current slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_valid <= 1'b0;
      r_d_instr <= '0;
    end else if (w_ready) begin
      r_d_valid <= bus.instr_valid;
      if (bus.instr_valid) r_d_instr <= bus.instr;
    end
  end

  // W register: bubbles while MUL is iterating and for illegal slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_valid <= 1'b0;
      r_w_rd    <= '0;
      r_w_data  <= '0;
    end else begin
      r_w_valid <= r_d_valid && w_ex_done && !w_dec.illegal;
      r_w_rd    <= w_rd_idx;
      r_w_data  <= w_result;
    end
  end

  // register file written from W at the end of the write-back cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (r_w_valid && r_w_rd != '0) begin
      r_regs[r_w_rd] <= r_w_data;
    end
  end

  // retire counter counts every write-back cycle, including rd==x0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_retire_cnt <= '0;
    else if (r_w_valid) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign bus.instr_ready = w_ready;
  assign bus.wb_valid    = r_w_valid;
  assign bus.wb_rd       = r_w_rd;
  assign bus.wb_data     = r_w_data;
  assign bus.illegal     = r_d_valid && w_dec.illegal;
  assign bus.retire_cnt  = r_retire_cnt;

endmodule
`default_nettype wire
